// File: rtl/gray_counter_div.sv
// gray_counter_div: N-bit up/down counter with a built-in synchronous prescaler.
// The counter advances once every (div+1) enabled cycles. It provides both a
// registered binary count and a registered Gray-coded count. A one-cycle wrap
// pulse (tc) accompanies each wrap. Everything runs on the single clk domain.
// The prescaler terminal acts as a clock-enable tick, so no divided clock exists.
module gray_counter_div #(
  parameter int WIDTH     = 4,
  parameter int DIV_WIDTH = 20
) (
  input  logic                 clk,
  input  logic                 res,
  input  logic                 en,
  input  logic                 up_dn,
  input  logic [DIV_WIDTH-1:0] div,
  input  logic                 load,
  input  logic [WIDTH-1:0]     load_val,
  output logic [WIDTH-1:0]     gray_out,
  output logic [WIDTH-1:0]     bin_out,
  output logic                 tick,
  output logic                 tc
);

  logic [DIV_WIDTH-1:0] prescaler;
  logic                 terminal;
  logic [WIDTH-1:0]     step_bin;
  logic                 wrap;

  // The terminal condition uses >= rather than ==. If div is lowered below
  // the running prescaler value, the next enabled edge produces a tick.
  // This prevents the prescaler from running all the way around its range.
  always_comb begin
    terminal = 1'b0;
    step_bin = '0;
    wrap     = 1'b0;
    terminal = (prescaler >= div);
    if (up_dn) begin
      step_bin = bin_out + WIDTH'(1);
      wrap     = (bin_out == {WIDTH{1'b1}});
    end else begin
      step_bin = bin_out - WIDTH'(1);
      wrap     = (bin_out == {WIDTH{1'b0}});
    end
  end

  // The update priority is reset, then load, then enabled counting, then hold.
  // The Gray encoding is computed from the next binary value. As a result,
  // gray_out and bin_out change on the same edge.
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      prescaler <= '0;
      bin_out   <= '0;
      gray_out  <= '0;
      tick      <= 1'b0;
      tc        <= 1'b0;
    end else if (load) begin
      prescaler <= '0;
      bin_out   <= load_val;
      gray_out  <= load_val ^ (load_val >> 1);
      tick      <= 1'b0;
      tc        <= 1'b0;
    end else if (en) begin
      if (terminal) begin
        prescaler <= '0;
        bin_out   <= step_bin;
        gray_out  <= step_bin ^ (step_bin >> 1);
        tick      <= 1'b1;
        tc        <= wrap;
      end else begin
        prescaler <= prescaler + DIV_WIDTH'(1);
        tick      <= 1'b0;
        tc        <= 1'b0;
      end
    end else begin
      tick <= 1'b0;
      tc   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_gray_counter_div.sv
// Testbench for gray_counter_div with WIDTH=3.
// A table of per-cycle vectors carries hand-computed expected outputs.
// Hand-written sequences cover the wrap-rate and async-reset cases.
module tb_gray_counter_div;

  localparam int WIDTH     = 3;
  localparam int DIV_WIDTH = 20;

  logic                 clk;
  logic                 res;
  logic                 en;
  logic                 up_dn;
  logic [DIV_WIDTH-1:0] div;
  logic                 load;
  logic [WIDTH-1:0]     load_val;
  logic [WIDTH-1:0]     gray_out;
  logic [WIDTH-1:0]     bin_out;
  logic                 tick;
  logic                 tc;

  int checks = 0;
  int errors = 0;

  gray_counter_div #(.WIDTH(WIDTH), .DIV_WIDTH(DIV_WIDTH)) dut (
    .clk      (clk),
    .res      (res),
    .en       (en),
    .up_dn    (up_dn),
    .div      (div),
    .load     (load),
    .load_val (load_val),
    .gray_out (gray_out),
    .bin_out  (bin_out),
    .tick     (tick),
    .tc       (tc)
  );

  // Clock generation
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic                 en;
    logic                 up_dn;
    logic [DIV_WIDTH-1:0] div;
    logic                 load;
    logic [WIDTH-1:0]     load_val;
    logic [WIDTH-1:0]     e_bin;
    logic [WIDTH-1:0]     e_gray;
    logic                 e_tick;
    logic                 e_tc;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic v_en, input logic v_up, input int v_div,
                     input logic v_load, input int v_lval, input int e_bin,
                     input int e_gray, input logic e_tick, input logic e_tc);
    vec_t v;
    v.en       = v_en;
    v.up_dn    = v_up;
    v.div      = DIV_WIDTH'(v_div);
    v.load     = v_load;
    v.load_val = WIDTH'(v_lval);
    v.e_bin    = WIDTH'(e_bin);
    v.e_gray   = WIDTH'(e_gray);
    v.e_tick   = e_tick;
    v.e_tc     = e_tc;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Advance one active edge, then settle away from it
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [WIDTH-1:0] to_gray(input logic [WIDTH-1:0] b);
    return b ^ (b >> 1);
  endfunction

  initial begin
    int tc_cnt;
    int tick_cnt;
    logic [WIDTH-1:0] m_bin;

    // Vector table (bin/gray after each edge, hand-computed)
    // Full up cycle with div=0; tc only on 7->0 (gray 100->000)
    add(1,1,0,0,0, 1,3'b001,1,0);
    add(1,1,0,0,0, 2,3'b011,1,0);
    add(1,1,0,0,0, 3,3'b010,1,0);
    add(1,1,0,0,0, 4,3'b110,1,0);
    add(1,1,0,0,0, 5,3'b111,1,0);
    add(1,1,0,0,0, 6,3'b101,1,0);
    add(1,1,0,0,0, 7,3'b100,1,0);
    add(1,1,0,0,0, 0,3'b000,1,1);
    // Prescale by 4 (div=3), starting with prescaler at 0
    add(1,1,3,0,0, 0,3'b000,0,0);
    add(1,1,3,0,0, 0,3'b000,0,0);
    add(1,1,3,0,0, 0,3'b000,0,0);
    add(1,1,3,0,0, 1,3'b001,1,0);
    add(1,1,3,0,0, 1,3'b001,0,0);
    add(1,1,3,0,0, 1,3'b001,0,0);
    add(1,1,3,0,0, 1,3'b001,0,0);
    add(1,1,3,0,0, 2,3'b011,1,0);
    // Down and wrap: load 0, then 0->7 (tc), then 7->6
    add(1,0,0,1,0, 0,3'b000,0,0);
    add(1,0,0,0,0, 7,3'b100,1,1);
    add(1,0,0,0,0, 6,3'b101,1,0);
    // Load collision with div=1: the load lands on the would-be tick edge
    add(1,1,1,0,0, 6,3'b101,0,0);
    add(1,1,1,1,5, 5,3'b111,0,0);
    add(1,1,1,0,0, 5,3'b111,0,0);
    add(1,1,1,0,0, 6,3'b101,1,0);
    // div=9: run the prescaler up to 6
    for (int i = 0; i < 6; i++) add(1,1,9,0,0, 6,3'b101,0,0);
    // en=0 for 10 cycles: everything holds
    for (int i = 0; i < 10; i++) add(0,1,9,0,0, 6,3'b101,0,0);
    // div drops to 2 with prescaler=6: immediate tick, then one every 3 cycles
    add(1,1,2,0,0, 7,3'b100,1,0);
    add(1,1,2,0,0, 7,3'b100,0,0);
    add(1,1,2,0,0, 7,3'b100,0,0);
    add(1,1,2,0,0, 0,3'b000,1,1);

    // Reset
    res = 1'b0; en = 1'b0; up_dn = 1'b1; div = '0; load = 1'b0; load_val = '0;
    #1;
    check("reset bin", 32'(bin_out), 32'd0);
    check("reset gray", 32'(gray_out), 32'd0);
    check("reset tick", 32'(tick), 32'd0);
    check("reset tc", 32'(tc), 32'd0);
    cycle();
    cycle();
    res = 1'b1;

    // Table-driven section
    for (int i = 0; i < vecs.size(); i++) begin
      en = vecs[i].en; up_dn = vecs[i].up_dn; div = vecs[i].div;
      load = vecs[i].load; load_val = vecs[i].load_val;
      cycle();
      check($sformatf("vec%0d bin", i),  32'(bin_out),  32'(vecs[i].e_bin));
      check($sformatf("vec%0d gray", i), 32'(gray_out), 32'(vecs[i].e_gray));
      check($sformatf("vec%0d tick", i), 32'(tick),     32'(vecs[i].e_tick));
      check($sformatf("vec%0d tc", i),   32'(tc),       32'(vecs[i].e_tc));
    end
    load = 1'b0;

    // Wrap rate: div=3 from bin 0 and prescaler 0 gives one tc per 32 clocks
    en = 1'b1; up_dn = 1'b1; div = DIV_WIDTH'(3);
    tc_cnt = 0; tick_cnt = 0; m_bin = '0;
    for (int i = 0; i < 32; i++) begin
      cycle();
      if ((i % 4) == 3) m_bin = m_bin + 3'd1;
      check($sformatf("rate%0d tick", i), 32'(tick), 32'((i % 4) == 3));
      check($sformatf("rate%0d gray", i), 32'(gray_out), 32'(to_gray(m_bin)));
      if (tc) tc_cnt++;
      if (tick) tick_cnt++;
    end
    check("rate tc count", 32'(tc_cnt), 32'd1);
    check("rate tick count", 32'(tick_cnt), 32'd8);
    check("rate final bin", 32'(bin_out), 32'd0);

    // Async reset mid-count: div=0, count up to 6
    div = '0;
    for (int i = 0; i < 6; i++) cycle();
    check("pre-reset bin", 32'(bin_out), 32'd6);
    #2;
    res = 1'b0;
    #1;
    check("async bin", 32'(bin_out), 32'd0);
    check("async gray", 32'(gray_out), 32'd0);
    check("async tick", 32'(tick), 32'd0);
    check("async tc", 32'(tc), 32'd0);
    cycle();
    check("held reset bin", 32'(bin_out), 32'd0);
    res = 1'b1;
    div = DIV_WIDTH'(3);
    for (int i = 0; i < 4; i++) begin
      cycle();
      check($sformatf("restart%0d bin", i), 32'(bin_out), (i == 3) ? 32'd1 : 32'd0);
      check($sformatf("restart%0d tick", i), 32'(tick), (i == 3) ? 32'd1 : 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/gray_counter_div.md
Name: gray_counter_div

Overview:
- Parametrised N-bit Gray-code counter with an integrated synchronous prescaler.
- Steps once every (div+1) clock cycles and supports up/down counting, enable, synchronous load and a wrap pulse.
- Replaces ripple-divided clocking: the whole block runs on a single clock domain and uses a clock-enable tick.
- Sits between the system clock and downstream display/encoder logic, which consumes gray_out and tc.

Parameters:
WIDTH, 4, counter width in bits (gray_out, bin_out, load_val); legal range 2..16
DIV_WIDTH, 20, prescaler width in bits; sets the maximum division of 2^DIV_WIDTH

Ports:
clk  input  1  system clock; all state updates on rising edge
res  input  1  asynchronous, active-low reset (0 = reset asserted)
en  input  1  count enable; 0 freezes prescaler and counter
up_dn  input  1  direction: 1 = up, 0 = down
div  input  DIV_WIDTH  prescale value; counter steps every div+1 enabled cycles
load  input  1  synchronous load strobe
load_val  input  WIDTH  binary value to load
gray_out  output  WIDTH  registered Gray code of the count
bin_out  output  WIDTH  registered binary count
tick  output  1  one-cycle pulse on every prescaler terminal event
tc  output  1  one-cycle pulse when a step wraps the counter

Behaviour:
- Reset:
  - res=0 asynchronously forces prescaler=0, bin_out=0, gray_out=0, tick=0, tc=0.
  - Release is sampled on the next rising clk edge; reset mid-operation discards all state.
- Single clock domain: no internally generated clocks; all flops clocked by clk.
- Prescaler (enabled cycles only, en=1, load=0):
  - If prescaler >= div: prescaler<=0, tick<=1, counter steps this edge.
  - Else: prescaler<=prescaler+1, tick<=0.
  - The >= compare means lowering div below the current prescaler value gives a tick on the next enabled edge; the prescaler never runs to 2^DIV_WIDTH.
  - div=0: tick every enabled cycle, so the counter steps every clock.
- Counter step on tick:
  - up_dn=1: bin<=bin+1, modulo 2^WIDTH.
  - up_dn=0: bin<=bin-1, modulo 2^WIDTH.
- Gray output:
  - gray_out <= next_bin ^ (next_bin >> 1), registered in the same edge as bin_out.
  - Zero extra latency relative to bin_out; consecutive gray_out values differ in exactly one bit.
- tc:
  - 1 for one cycle on the edge where a step takes bin from all-ones to 0 (up) or from 0 to all-ones (down); otherwise 0.
  - Never asserted by load.
- Direction change: takes effect on the next tick; no reset of the prescaler.
- en=0 (and load=0): prescaler, bin_out and gray_out hold; tick<=0, tc<=0.
- Load (highest priority after reset, independent of en and tick):
  - Sets bin<=load_val, gray_out<=gray(load_val) and prescaler<=0.
  - Drives tick<=0, tc<=0.
  - The next step occurs div+1 enabled cycles after the load edge.
- Simultaneous load and tick condition: load wins; no step and no tc.
- Latency: tick, tc, bin_out and gray_out all update on the same edge that the prescaler terminal is reached.

Test Plan:
- Reset and full cycle: WIDTH=3, div=0, en=1, up_dn=1 from reset.
  - gray_out sequence is 000,001,011,010,110,111,101,100,000, one step per clk.
  - tc=1 only on the 100->000 edge.
- Prescale: div=3, en=1, up.
  - tick high every 4th cycle; bin_out goes 0,0,0,0,1,1,1,1,2.
  - tc pulses once per 32 clocks (WIDTH=3).
- Down and wrap: load_val=0, up_dn=0, div=0.
  - bin_out 0->7->6; gray_out 000->100->101.
  - tc=1 on the 0->7 edge only.
- Load collision: div=1, load asserted on the tick edge with load_val=5.
  - bin_out=5, gray_out=111, tc=0, tick=0.
  - Next step (to 6) occurs 2 cycles later.
- Enable and div change: en=0 for 10 cycles mid-count, then div reduced from 9 to 2 while prescaler=6.
  - Outputs hold during en=0.
  - After en=1, tick fires on the next edge, then every 3 cycles.
- Async reset mid-count: res=0 asserted between edges at bin_out=6.
  - All outputs 0 immediately, before the next clk edge.
  - After release, counting restarts from 0 with a full div+1 wait.
